// File: rtl/tdm_demultiplexer_if.sv
// ----------------------------------------------------------------------------
// tdm_demultiplexer_if
//   Bundles the serial sample stream and the demultiplexed frame outputs of
//   tdm_demultiplexer.
//
//   Signals
//     en          sample-valid; din/sync are meaningful only when en=1
//     sync        frame-start marker, marks din as the slot-0 bit
//     din         serial time-division data bit
//     err_clr     clears the sticky sync_err flag
//     y[3:0]      last complete frame, y[k] = bit received in slot k
//     frame_valid one-cycle pulse on each y update
//     slot[1:0]   slot the next qualified sample will occupy
//     sync_err    sticky flag, sync seen mid-frame
//
//   Modports
//     master  stream source: drives en/sync/din/err_clr, observes outputs
//     slave   the demultiplexer itself
// ----------------------------------------------------------------------------
interface tdm_demultiplexer_if;
    logic       en;
    logic       sync;
    logic       din;
    logic       err_clr;
    logic [3:0] y;
    logic       frame_valid;
    logic [1:0] slot;
    logic       sync_err;

    modport master (
        output en, sync, din, err_clr,
        input  y, frame_valid, slot, sync_err
    );

    modport slave (
        input  en, sync, din, err_clr,
        output y, frame_valid, slot, sync_err
    );
endinterface

// File: rtl/tdm_demultiplexer.sv
// ----------------------------------------------------------------------------
// tdm_demultiplexer
//   Four-channel time-division demultiplexer: the inverse of a 4-to-1 mux.
//   Each qualified serial bit is stored in the accumulator position given by
//   the slot counter. When slot 3 is filled, the full frame is published on
//   y together with a one-cycle frame_valid pulse. A sync marker forces the
//   current bit into slot 0. If sync arrives while a frame is partly
//   assembled, that partial frame is dropped and sync_err is raised.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    tdm_demultiplexer_if.slave (en, sync, din, err_clr in;
//            y, frame_valid, slot, sync_err out)
// ----------------------------------------------------------------------------
module tdm_demultiplexer (
    input  logic                  clk,
    input  logic                  rst_n,
    tdm_demultiplexer_if.slave    bus
);

    logic [3:0] acc_q, acc_d;
    logic [1:0] slot_q, slot_d;
    logic [3:0] y_q, y_d;
    logic       frame_valid_q, frame_valid_d;
    logic       sync_err_q, sync_err_d;
    logic       mid_frame_sync;

    always_comb begin
        acc_d          = acc_q;
        slot_d         = slot_q;
        y_d            = y_q;
        frame_valid_d  = 1'b0;
        mid_frame_sync = 1'b0;

        if (bus.en) begin
            if (bus.sync) begin
                // Realign: this bit starts a fresh frame in slot 0.
                acc_d          = {3'b000, bus.din};
                slot_d         = 2'd1;
                mid_frame_sync = (slot_q != 2'd0);
            end else begin
                acc_d[slot_q] = bus.din;
                slot_d        = slot_q + 2'd1;
                if (slot_q == 2'd3) begin
                    // Publish directly from din so the frame is visible one
                    // cycle after its last bit.
                    y_d           = {bus.din, acc_q[2:0]};
                    frame_valid_d = 1'b1;
                end
            end
        end

        // A new error in the same cycle as a clear must win.
        if (mid_frame_sync) begin
            sync_err_d = 1'b1;
        end else if (bus.err_clr) begin
            sync_err_d = 1'b0;
        end else begin
            sync_err_d = sync_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q         <= 4'b0000;
            slot_q        <= 2'd0;
            y_q           <= 4'b0000;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            slot_q        <= slot_d;
            y_q           <= y_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign bus.y           = y_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.slot        = slot_q;
    assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// ----------------------------------------------------------------------------
// tb_tdm_demultiplexer
//   Directed bench for tdm_demultiplexer. Inputs change 1 time unit after a
//   rising edge and outputs are sampled 1 time unit after the next one.
// ----------------------------------------------------------------------------
module tb_tdm_demultiplexer;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    tdm_demultiplexer_if bus ();

    tdm_demultiplexer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs and wait until the edge has taken effect.
    task automatic cyc(input logic en, input logic sync, input logic din, input logic clr);
        bus.en      = en;
        bus.sync    = sync;
        bus.din     = din;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] y, input logic fv,
                           input logic [1:0] slot, input logic err);
        chk({tag, ".y"},           bus.y,                  y);
        chk({tag, ".frame_valid"}, {3'b000, bus.frame_valid}, {3'b000, fv});
        chk({tag, ".slot"},        {2'b00, bus.slot},      {2'b00, slot});
        chk({tag, ".sync_err"},    {3'b000, bus.sync_err}, {3'b000, err});
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk_all("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;

        // Basic frame with leading sync: 1,0,1,1 -> 1101
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk_all("f1.s0", 4'b0000, 1'b0, 2'd1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("f1.s1", 4'b0000, 1'b0, 2'd2, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("f1.s2", 4'b0000, 1'b0, 2'd3, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("f1.s3", 4'b1101, 1'b1, 2'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("f1.idle", 4'b1101, 1'b0, 2'd0, 1'b0);

        // Same stream with a 3-cycle en gap after slot 1; sync/din are garbage there
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("gap.s1", 4'b1101, 1'b0, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0);
            chk_all("gap.hold", 4'b1101, 1'b0, 2'd2, 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("gap.s2", 4'b1101, 1'b0, 2'd3, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("gap.s3", 4'b1101, 1'b1, 2'd0, 1'b0);

        // Back-to-back frames without sync: 0,1,0,0 then 1,1,1,1
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("b2b.a0", 4'b1101, 1'b0, 2'd1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("b2b.a2", 4'b1101, 1'b0, 2'd3, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("b2b.a3", 4'b0010, 1'b1, 2'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("b2b.b0", 4'b0010, 1'b0, 2'd1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("b2b.b1", 4'b0010, 1'b0, 2'd2, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("b2b.b2", 4'b0010, 1'b0, 2'd3, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("b2b.b3", 4'b1111, 1'b1, 2'd0, 1'b0);

        // Mid-frame sync: 1,1 then sync din=0, then 1,1,1 -> 1110
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("err.pre", 4'b1111, 1'b0, 2'd2, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("err.sync", 4'b1111, 1'b0, 2'd1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("err.s2", 4'b1111, 1'b0, 2'd3, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("err.s3", 4'b1110, 1'b1, 2'd0, 1'b1);

        // err_clr colliding with a new mid-frame sync: set wins
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk_all("clr.collide", 4'b1110, 1'b0, 2'd1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("clr.alone", 4'b1110, 1'b0, 2'd1, 1'b0);
        // Finish this frame: slot0=0 (from sync), then 1,0,1 -> 1010
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("clr.frame", 4'b1010, 1'b1, 2'd0, 1'b0);
        // Sync at slot 0 is normal operation
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk_all("sync.slot0", 4'b1010, 1'b0, 2'd1, 1'b0);

        // Reset mid-frame, then a complete frame 0,1,1,0 -> 0110
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("rst.pre", 4'b1010, 1'b0, 2'd2, 1'b0);
        rst_n = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("rst.mid", 4'b0000, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("rst.s0", 4'b0000, 1'b0, 2'd1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("rst.frame", 4'b0110, 1'b1, 2'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("rst.after", 4'b0110, 1'b0, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tdm_demultiplexer.md
TDM_DEMULTIPLEXER -- requirements
Module: tdm_demultiplexer

Interface
- REQ-001: Block SHALL have no parameters; channel count is fixed at 4 and slot index width at 2.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  reset, synchronous and active-low.
- REQ-004: en  input  1  sample-valid; din/sync are sampled only when en=1.
- REQ-005: sync  input  1  frame-start marker; qualified by en; marks din as the slot-0 bit.
- REQ-006: din  input  1  serial time-division data bit.
- REQ-007: err_clr  input  1  clears sync_err.
- REQ-008: y  output  4  last complete frame; y[k] = bit received in slot k.
- REQ-009: frame_valid  output  1  one-cycle pulse on each y update.
- REQ-010: slot  output  2  slot index the next qualified sample will occupy.
- REQ-011: sync_err  output  1  sticky flag for a sync arriving mid-frame.

Function
- REQ-012: Internal 4-bit accumulator acc and 2-bit slot counter SHALL implement the inverse of the team 4-to-1 mux: the bit arriving while slot=k SHALL be routed to channel k.
- REQ-013: en=0: acc, slot, y SHALL hold; frame_valid SHALL be 0 next cycle; sync and din SHALL be ignored.
- REQ-014: en=1, sync=0: acc[slot] <= din; slot <= slot+1 (mod 4; 3 wraps to 0).
- REQ-015: en=1, sync=1: acc[0] <= din; acc[3:1] <= 0; slot <= 1, regardless of current slot.
- REQ-016: If en=1, sync=1 and slot!=0, the partial frame SHALL be discarded (no y update, no frame_valid) and sync_err SHALL be set to 1.
- REQ-017: en=1, sync=0, slot=3: y <= {din, acc[2:0]} and frame_valid <= 1 on the same edge; y/frame_valid visible one cycle after the slot-3 sample (latency 1 clock).
- REQ-018: frame_valid SHALL be 1 for exactly one cycle per completed frame; back-to-back frames at full rate SHALL give one pulse every 4 qualified samples.
- REQ-019: y SHALL hold its value between frames; it changes only per REQ-017.
- REQ-020: First frame after reset SHALL complete without a preceding sync (slot starts at 0); sync is not mandatory for alignment.
- REQ-021: sync with slot=0 SHALL be normal operation: no error, same action as REQ-015.
- REQ-022: err_clr=1 SHALL clear sync_err next cycle; if a new error event (REQ-016) occurs in the same cycle, set SHALL win (sync_err=1).
- REQ-023: slot output SHALL be the registered counter value, not a look-ahead.

Reset
- REQ-024: On rising clk with rst_n=0: y=4'b0000, frame_valid=0, slot=2'b00, sync_err=0, acc=0; all inputs ignored that cycle.
- REQ-025: Reset mid-frame SHALL discard the partial frame with no frame_valid pulse; the first qualified sample after rst_n=1 occupies slot 0.

Verification
- REQ-026: Reset, then en=1 with sync=1 on the first sample, din=1,0,1,1 on 4 consecutive cycles -> one cycle later y=4'b1101, frame_valid=1 for 1 cycle, slot=0, sync_err=0.
- REQ-027: Same stream with en deasserted for 3 cycles between slot 1 and slot 2 -> y=4'b1101 still, frame_valid pulse delayed by exactly 3 cycles, slot holds at 2 during the gap.
- REQ-028: Sample slot0=1, slot1=1, then sync=1, din=0 -> sync_err=1, slot=1, no frame_valid; next 3 samples 1,1,1 -> y=4'b1110.
- REQ-029: sync_err=1, then err_clr=1 in the same cycle as a new mid-frame sync -> sync_err stays 1; err_clr alone next cycle -> sync_err=0.
- REQ-030: Continuous en=1 for 8 cycles, din pattern 0,1,0,0,1,1,1,1 -> y=4'b0010 then 4'b1111, frame_valid pulses exactly 4 cycles apart.
- REQ-031: rst_n=0 asserted after 2 samples of a frame -> next edge y=0, slot=0, frame_valid=0; following 4 samples form a complete frame from slot 0.
